// File: rtl/led_status_ctrl.sv
// Board-status controller: sticky HALT on core exit, RUN-cycle counter, MMIO LED register.
// Optional heartbeat blinker on the top LED is compiled in with `define LED_HEARTBEAT_EN.
module led_status_ctrl #(
  parameter int unsigned          WORD_LEN = 32'd32,
  parameter int unsigned          LED_NUM  = 32'd6,
  parameter logic [WORD_LEN-1:0]  LED_ADDR = 32'h0000_1000,
  parameter int unsigned          HB_DIV   = 32'd13_500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                exit,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic                wen,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [LED_NUM-1:0]  led,
  output logic                halted,
  output logic [WORD_LEN-1:0] cycle_count
);

`ifdef LED_HEARTBEAT_EN
  localparam int unsigned REG_W = LED_NUM - 32'd2;
`else
  localparam int unsigned REG_W = LED_NUM - 32'd1;
`endif

  localparam logic [WORD_LEN-1:0] CNT_MAX = {WORD_LEN{1'b1}};
  localparam logic [WORD_LEN-1:0] CNT_ONE = WORD_LEN'(32'd1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [WORD_LEN-1:0] cycle_count_r;
  logic [REG_W-1:0]    led_reg_r;
  logic                led_wr_s;
  logic [LED_NUM-1:0]  led_s;
  logic                unused_s;

  // Next-state decode: any sampled exit in RUN halts; HALT only leaves via reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (exit) begin
          state_nxt_s = ST_HALT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // RUN-cycle counter; the halting edge still counts, and it saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_r <= {WORD_LEN{1'b0}};
    end else if ((state_r == ST_RUN) && (cycle_count_r != CNT_MAX)) begin
      cycle_count_r <= cycle_count_r + CNT_ONE;
    end else begin
      cycle_count_r <= cycle_count_r;
    end
  end

  assign led_wr_s = (state_r == ST_RUN) && wen && (d_addr == LED_ADDR);

  // MMIO LED register, snooped from core stores with a full-width address match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg_r <= {REG_W{1'b0}};
    end else if (led_wr_s) begin
      led_reg_r <= wdata[REG_W-1:0];
    end else begin
      led_reg_r <= led_reg_r;
    end
  end

`ifdef LED_HEARTBEAT_EN
  localparam int unsigned     HB_W    = $clog2(HB_DIV);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_DIV - 32'd1);
  localparam logic [HB_W-1:0] HB_ONE  = HB_W'(32'd1);

  logic [HB_W-1:0] hb_cnt_r;
  logic            hb_r;

  // Heartbeat divider: toggles hb on each wrap, frozen while halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_r <= {HB_W{1'b0}};
      hb_r     <= 1'b0;
    end else if (state_r == ST_RUN) begin
      if (hb_cnt_r == HB_LAST) begin
        hb_cnt_r <= {HB_W{1'b0}};
        hb_r     <= ~hb_r;
      end else begin
        hb_cnt_r <= hb_cnt_r + HB_ONE;
        hb_r     <= hb_r;
      end
    end else begin
      hb_cnt_r <= hb_cnt_r;
      hb_r     <= hb_r;
    end
  end

  // LED map: halt, register field, then heartbeat (solid when halted).
  always_comb begin
    led_s                 = {LED_NUM{1'b0}};
    led_s[0]              = (state_r == ST_HALT);
    led_s[LED_NUM-2:1]    = led_reg_r;
    if (state_r == ST_HALT) begin
      led_s[LED_NUM-1] = 1'b1;
    end else begin
      led_s[LED_NUM-1] = hb_r;
    end
  end

  assign unused_s = ^wdata[WORD_LEN-1:REG_W];
`else
  // LED map: halt bit, then the register field fills the remaining pins.
  always_comb begin
    led_s              = {LED_NUM{1'b0}};
    led_s[0]           = (state_r == ST_HALT);
    led_s[LED_NUM-1:1] = led_reg_r;
  end

  assign unused_s = ^{wdata[WORD_LEN-1:REG_W], HB_DIV[0]};
`endif

  assign led         = led_s;
  assign halted      = (state_r == ST_HALT);
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed self-checking bench for led_status_ctrl (LED_NUM=6, HB_DIV=4, WORD_LEN=32).
// Expectations follow whichever LED_HEARTBEAT_EN build is being compiled.
module tb_led_status_ctrl;

  localparam int unsigned WORD_LEN = 32;
  localparam int unsigned LED_NUM  = 6;
  localparam logic [31:0] LED_ADDR = 32'h0000_1000;
  localparam int unsigned HB_DIV   = 4;
`ifdef LED_HEARTBEAT_EN
  localparam int unsigned REG_W = LED_NUM - 2;
  localparam bit          HB_ON = 1'b1;
`else
  localparam int unsigned REG_W = LED_NUM - 1;
  localparam bit          HB_ON = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic                exit;
  logic [WORD_LEN-1:0] d_addr;
  logic                wen;
  logic [WORD_LEN-1:0] wdata;
  logic [LED_NUM-1:0]  led;
  logic                halted;
  logic [WORD_LEN-1:0] cycle_count;

  int n_checks;
  int n_pass;
  int n_edges;
  logic [REG_W-1:0] exp_reg;

  led_status_ctrl #(
    .WORD_LEN (WORD_LEN),
    .LED_NUM  (LED_NUM),
    .LED_ADDR (LED_ADDR),
    .HB_DIV   (HB_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .exit        (exit),
    .d_addr      (d_addr),
    .wen         (wen),
    .wdata       (wdata),
    .led         (led),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Heartbeat level after e edges of RUN since reset release.
  function automatic logic hb_exp(input int e);
    return ((e / HB_DIV) % 2) == 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) n_edges++;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    exit   = 1'b0;
    wen    = 1'b0;
    d_addr = 32'h0;
    wdata  = 32'h0;
    n_edges = 0;
    exp_reg = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    wen = 1'b1; d_addr = a; wdata = d;
    tick();
    wen = 1'b0; d_addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; exit = 1'b0; wen = 1'b0; d_addr = 32'h0; wdata = 32'h0;
    #1;
    n_checks++; if (led !== 6'b000000) $display("FAIL reset_led: got %b expected %b", led, 6'b0); else n_pass++;
    n_checks++; if (cycle_count !== 32'd0) $display("FAIL reset_count: got %0d expected 0", cycle_count); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else n_pass++;
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_checks++;
      if (led !== {hb_exp(i) & HB_ON, 5'b00000})
        $display("FAIL idle_led_e%0d: got %b expected %b", i, led, {hb_exp(i) & HB_ON, 5'b00000});
      else n_pass++;
    end
    n_checks++; if (cycle_count !== 32'd10) $display("FAIL idle_count: got %0d expected 10", cycle_count); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL idle_halted: got %b expected 0", halted); else n_pass++;
  endtask

  task automatic test_mmio();
    logic [31:0] d;
    apply_reset();
    tick(); tick();
    d = 32'hFFFF_FFF5;
    write(LED_ADDR, d);
    exp_reg = d[REG_W-1:0];
    n_checks++; if (led[REG_W:1] !== exp_reg) $display("FAIL mmio_write: got %b expected %b", led[REG_W:1], exp_reg); else n_pass++;
    write(32'h0000_1004, 32'h0);
    n_checks++; if (led[REG_W:1] !== exp_reg) $display("FAIL mmio_other_addr: got %b expected %b", led[REG_W:1], exp_reg); else n_pass++;
    write(32'h8000_1000, 32'h0);
    n_checks++; if (led[REG_W:1] !== exp_reg) $display("FAIL mmio_high_addr: got %b expected %b", led[REG_W:1], exp_reg); else n_pass++;
    wen = 1'b0; d_addr = LED_ADDR; wdata = 32'h0;
    tick();
    d_addr = 32'h0;
    n_checks++; if (led[REG_W:1] !== exp_reg) $display("FAIL mmio_no_wen: got %b expected %b", led[REG_W:1], exp_reg); else n_pass++;
    n_checks++; if (led[0] !== 1'b0) $display("FAIL mmio_led0: got %b expected 0", led[0]); else n_pass++;
    n_checks++; if (HB_ON && led[5] !== hb_exp(n_edges)) $display("FAIL mmio_hb: got %b expected %b", led[5], hb_exp(n_edges)); else n_pass++;
  endtask

  task automatic test_exit();
    apply_reset();
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (halted !== 1'b0) $display("FAIL exit_pre: got %b expected 0", halted); else n_pass++;
    exit = 1'b1;
    tick();
    exit = 1'b0;
    n_checks++; if (halted !== 1'b1) $display("FAIL exit_halted: got %b expected 1", halted); else n_pass++;
    n_checks++; if (led[0] !== 1'b1) $display("FAIL exit_led0: got %b expected 1", led[0]); else n_pass++;
    n_checks++; if (cycle_count !== 32'd7) $display("FAIL exit_count: got %0d expected 7", cycle_count); else n_pass++;
    n_checks++; if (led[5] !== HB_ON) $display("FAIL exit_led5: got %b expected %b", led[5], HB_ON); else n_pass++;
    tick(); tick(); tick();
    write(LED_ADDR, 32'hF);
    n_checks++; if (led[REG_W:1] !== exp_reg) $display("FAIL halt_write: got %b expected %b", led[REG_W:1], exp_reg); else n_pass++;
    n_checks++; if (cycle_count !== 32'd7) $display("FAIL halt_count: got %0d expected 7", cycle_count); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_sticky: got %b expected 1", halted); else n_pass++;
  endtask

  task automatic test_exit_and_write();
    logic [31:0] d;
    apply_reset();
    tick(); tick();
    d = 32'h3;
    exit = 1'b1;
    write(LED_ADDR, d);
    exit = 1'b0;
    exp_reg = d[REG_W-1:0];
    n_checks++; if (led[REG_W:1] !== exp_reg) $display("FAIL exitwr_reg: got %b expected %b", led[REG_W:1], exp_reg); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL exitwr_halted: got %b expected 1", halted); else n_pass++;
    n_checks++; if (cycle_count !== 32'd3) $display("FAIL exitwr_count: got %0d expected 3", cycle_count); else n_pass++;
  endtask

  task automatic test_reset_in_halt();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (led !== 6'b000000) $display("FAIL arst_led: got %b expected 000000", led); else n_pass++;
    n_checks++; if (cycle_count !== 32'd0) $display("FAIL arst_count: got %0d expected 0", cycle_count); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL arst_halted: got %b expected 0", halted); else n_pass++;
    n_edges = 0;
    exp_reg = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++; if (cycle_count !== 32'd1) $display("FAIL arst_resume1: got %0d expected 1", cycle_count); else n_pass++;
    tick(); tick();
    n_checks++; if (cycle_count !== 32'd3) $display("FAIL arst_resume3: got %0d expected 3", cycle_count); else n_pass++;
  endtask

  task automatic test_led_hold();
    logic [31:0] d;
    apply_reset();
    d = 32'h1F;
    write(LED_ADDR, d);
    exp_reg = d[REG_W-1:0];
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (led !== {(HB_ON ? hb_exp(n_edges) : exp_reg[REG_W-1]), exp_reg[3:0], 1'b0})
        $display("FAIL hold_led_e%0d: got %b expected %b", n_edges, led,
                 {(HB_ON ? hb_exp(n_edges) : exp_reg[REG_W-1]), exp_reg[3:0], 1'b0});
      else n_pass++;
      tick();
    end
    n_checks++; if (cycle_count !== 32'd21) $display("FAIL hold_count: got %0d expected 21", cycle_count); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_edges  = 0;
    exp_reg  = '0;
    test_reset();
    test_mmio();
    test_exit();
    test_exit_and_write();
    test_reset_in_halt();
    test_led_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
